smmha_tcdm_responder: RTL and testbench

- Multi-port TCDM slave memory model. It answers the accelerator's TCDM master ports (req/gnt/add/wen/be/data, r_data/r_valid).
- Word-interleaved banked SRAM with per-bank round-robin conflict arbitration and a fixed 1-cycle response latency.
- Used as the shared-memory end of the smmha cluster testbench, and as a stand-in L1 for FPGA bring-up.

---
 rtl/smmha_package.sv | 23 ++
 rtl/smmha_tcdm_bank_arb.sv | 47 ++++
 rtl/smmha_tcdm_responder.sv | 167 ++++++++++++++++
 tb/tb_smmha_tcdm_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smmha_package.sv
// Shared TCDM types and constants for the smmha responder and its bank arbiter.
package smmha_package;

    localparam int TCDM_ADDR_W = 32;
    localparam int TCDM_DATA_W = 32;
    localparam int TCDM_BE_W   = 4;

    localparam logic [TCDM_DATA_W-1:0] TCDM_ERR_RDATA = 32'hDEAD_BEEF;
    localparam logic [15:0]            TCDM_LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic [TCDM_ADDR_W-1:0] add;
        logic                   wen;
        logic [TCDM_BE_W-1:0]   be;
        logic [TCDM_DATA_W-1:0] data;
    } tcdm_req_t;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/smmha_tcdm_bank_arb.sv
// Per-bank round-robin arbiter: one-hot grant, winner index and rr pointer.
module smmha_tcdm_bank_arb
    import smmha_package::*;
#(
    parameter int MP     = 2,
    parameter int PORT_W = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [MP-1:0]     req_i,
    output logic [MP-1:0]     gnt_o,
    output logic [PORT_W-1:0] idx_o,
    output logic              vld_o
);

    logic [PORT_W-1:0] rr_q;
    logic [PORT_W-1:0] rr_d;
    int                cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = 0;
        for (int k = 0; k < MP; k++) begin
            cand = (int'(rr_q) + k) % MP;
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                idx_o       = PORT_W'(cand);
                gnt_o[cand] = 1'b1;
            end
        end
        rr_d = rr_q;
        if (vld_o) begin
            rr_d = (int'(idx_o) == MP - 1) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/smmha_tcdm_responder.sv
// Banked TCDM slave memory with per-bank round-robin and 1-cycle responses.
// Optional random backpressure per port when SMMHA_TCDM_STALL_EN is defined.
module smmha_tcdm_responder
    import smmha_package::*;
#(
    parameter int          MP         = 2,
    parameter int          N_BANKS    = 4,
    parameter int          BANK_WORDS = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [MP-1:0]                    tcdm_req,
    output logic [MP-1:0]                    tcdm_gnt,
    input  logic [MP-1:0][TCDM_ADDR_W-1:0]   tcdm_add,
    input  logic [MP-1:0]                    tcdm_wen,
    input  logic [MP-1:0][TCDM_BE_W-1:0]     tcdm_be,
    input  logic [MP-1:0][TCDM_DATA_W-1:0]   tcdm_data,
    output logic [MP-1:0][TCDM_DATA_W-1:0]   tcdm_r_data,
    output logic [MP-1:0]                    tcdm_r_valid,
    output logic [MP-1:0]                    err_o
);

    localparam int BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int ROW_W  = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam int PORT_W = (MP > 1) ? $clog2(MP) : 1;
    localparam logic [31:0] SPAN = 32'(4 * N_BANKS * BANK_WORDS);

    tcdm_req_t         req_s [MP];
    logic [31:0]       off   [MP];
    logic [31:0]       widx  [MP];
    logic [BANK_W-1:0] bank  [MP];
    logic [ROW_W-1:0]  row   [MP];
    logic [MP-1:0]     oor;
    logic [MP-1:0]     stall;

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            req_s[p] = '{add: tcdm_add[p], wen: tcdm_wen[p],
                         be: tcdm_be[p], data: tcdm_data[p]};
            off[p]   = req_s[p].add - BASE_ADDR;
            widx[p]  = off[p] >> 2;
            oor[p]   = (off[p] >= SPAN);
            bank[p]  = BANK_W'(widx[p] % 32'(N_BANKS));
            row[p]   = ROW_W'(widx[p] / 32'(N_BANKS));
        end
    end

`ifdef SMMHA_TCDM_STALL_EN
    logic [15:0] lfsr_q [MP];
    logic [15:0] lfsr_d [MP];

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            lfsr_d[p] = lfsr16_next(lfsr_q[p]);
            stall[p]  = (lfsr_q[p][1:0] == 2'b00);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (rst_i) begin
                lfsr_q[p] <= TCDM_LFSR_SEED ^ 16'(p);
            end else begin
                lfsr_q[p] <= lfsr_d[p];
            end
        end
    end
`else
    always_comb stall = '0;
`endif

    // Stalled and out-of-range ports never enter bank contention
    logic [MP-1:0]     bank_req [N_BANKS];
    logic [MP-1:0]     bank_gnt [N_BANKS];
    logic [PORT_W-1:0] bank_idx [N_BANKS];
    logic [N_BANKS-1:0] bank_vld;

    always_comb begin
        for (int b = 0; b < N_BANKS; b++) begin
            for (int p = 0; p < MP; p++) begin
                bank_req[b][p] = tcdm_req[p] & ~stall[p] & ~oor[p]
                               & (int'(bank[p]) == b);
            end
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        smmha_tcdm_bank_arb #(
            .MP     (MP),
            .PORT_W (PORT_W)
        ) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req_i (bank_req[b]),
            .gnt_o (bank_gnt[b]),
            .idx_o (bank_idx[b]),
            .vld_o (bank_vld[b])
        );
    end

    always_comb begin
        tcdm_gnt = tcdm_req & ~stall & oor;
        for (int b = 0; b < N_BANKS; b++) begin
            tcdm_gnt = tcdm_gnt | bank_gnt[b];
        end
    end

    logic [TCDM_DATA_W-1:0] mem_q [N_BANKS][BANK_WORDS];
    logic [N_BANKS-1:0]     we;
    logic [ROW_W-1:0]       wrow  [N_BANKS];
    logic [TCDM_BE_W-1:0]   wbe   [N_BANKS];
    logic [TCDM_DATA_W-1:0] wdata [N_BANKS];

    always_comb begin
        for (int b = 0; b < N_BANKS; b++) begin
            we[b]    = bank_vld[b] & ~req_s[bank_idx[b]].wen & ~rst_i;
            wrow[b]  = row[bank_idx[b]];
            wbe[b]   = req_s[bank_idx[b]].be;
            wdata[b] = req_s[bank_idx[b]].data;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < N_BANKS; b++) begin
            for (int i = 0; i < TCDM_BE_W; i++) begin
                if (we[b] && wbe[b][i]) begin
                    mem_q[b][wrow[b]][8*i +: 8] <= wdata[b][8*i +: 8];
                end
            end
        end
    end

    logic [MP-1:0][TCDM_DATA_W-1:0] rdata_d, rdata_q;
    logic [MP-1:0]                  rvalid_q, err_q;

    // Reads see pre-edge contents; a same-bank write cannot share the cycle
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            rdata_d[p] = '0;
            if (tcdm_gnt[p]) begin
                if (oor[p]) begin
                    rdata_d[p] = TCDM_ERR_RDATA;
                end else if (req_s[p].wen) begin
                    rdata_d[p] = mem_q[bank[p]][row[p]];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= '0;
        end else begin
            rvalid_q <= tcdm_gnt;
            rdata_q  <= rdata_d;
            err_q    <= tcdm_gnt & oor;
        end
    end

    assign tcdm_r_valid = rvalid_q;
    assign tcdm_r_data  = rdata_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_smmha_tcdm_responder.sv
// Randomized bench for smmha_tcdm_responder against a word-level memory model.
module tb_smmha_tcdm_responder;
    import smmha_package::*;

    localparam int          MP   = 2;
    localparam int          NB   = 4;
    localparam int          BWD  = 256;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] SPAN = 32'(4 * NB * BWD);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [MP-1:0]        req, gnt, wen, rv, err;
    logic [MP-1:0][31:0]  add, wdat, rdat;
    logic [MP-1:0][3:0]   be;

    always #5 clk = ~clk;

    smmha_tcdm_responder #(
        .MP(MP), .N_BANKS(NB), .BANK_WORDS(BWD), .BASE_ADDR(BASE)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tcdm_req     (req),
        .tcdm_gnt     (gnt),
        .tcdm_add     (add),
        .tcdm_wen     (wen),
        .tcdm_be      (be),
        .tcdm_data    (wdat),
        .tcdm_r_data  (rdat),
        .tcdm_r_valid (rv),
        .err_o        (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    logic [31:0] mmem [int unsigned];
    int          rr [NB];
    logic [15:0] lf [MP];
    bit          e_rv [MP];
    bit          e_err [MP];
    bit          e_known [MP];
    logic [31:0] e_rd [MP];

    // One clock: model grants/responses from the rules, then check the DUT
    task automatic step(input bit r, output logic [MP-1:0] g, output logic [MP-1:0] o);
        logic [31:0] off;
        logic [31:0] w;
        int unsigned key;
        int  bk [MP];
        bit  oor [MP];
        bit  msk [MP];
        bit  done;
        int  q;
        rst = r;
        #1;
        g = '0;
        o = gnt;
        for (int p = 0; p < MP; p++) begin
            off    = add[p] - BASE;
            oor[p] = (off >= SPAN);
            bk[p]  = int'((off >> 2) % NB);
            msk[p] = 1'b0;
`ifdef SMMHA_TCDM_STALL_EN
            msk[p] = (lf[p][1:0] == 2'b00);
`endif
            if (req[p] && !msk[p] && oor[p]) g[p] = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            done = 1'b0;
            for (int k = 0; k < MP; k++) begin
                q = (rr[b] + k) % MP;
                if (!done && req[q] && !msk[q] && !oor[q] && bk[q] == b) begin
                    done  = 1'b1;
                    g[q]  = 1'b1;
                    rr[b] = (q + 1) % MP;
                end
            end
            if (r) rr[b] = 0;
        end
        for (int p = 0; p < MP; p++) begin
            chk($sformatf("gnt%0d", p), 32'(gnt[p]), 32'(g[p]));
            off        = add[p] - BASE;
            key        = off >> 2;
            e_rv[p]    = g[p] && !r;
            e_err[p]   = e_rv[p] && oor[p];
            e_known[p] = 1'b1;
            e_rd[p]    = '0;
            if (e_rv[p] && oor[p]) e_rd[p] = 32'hDEAD_BEEF;
            else if (e_rv[p] && wen[p]) begin
                if (mmem.exists(key)) e_rd[p] = mmem[key];
                else e_known[p] = 1'b0;
            end
        end
        for (int p = 0; p < MP; p++) begin
            off = add[p] - BASE;
            key = off >> 2;
            if (e_rv[p] && !oor[p] && !wen[p] && (mmem.exists(key) || be[p] == 4'hF)) begin
                w = mmem.exists(key) ? mmem[key] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (be[p][i]) w[8*i +: 8] = wdat[p][8*i +: 8];
                mmem[key] = w;
            end
        end
        @(posedge clk);
        for (int p = 0; p < MP; p++)
            lf[p] = r ? (TCDM_LFSR_SEED ^ 16'(p)) : lfsr16_next(lf[p]);
        @(negedge clk);
        for (int p = 0; p < MP; p++) begin
            chk($sformatf("rvalid%0d", p), 32'(rv[p]), 32'(e_rv[p]));
            chk($sformatf("err%0d", p), 32'(err[p]), 32'(e_err[p]));
            if (e_rv[p] && e_known[p])
                chk($sformatf("rdata%0d", p), rdat[p], e_rd[p]);
        end
    endtask

    task automatic set_req(input int p, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        req[p]  = 1'b1;
        wen[p]  = w;
        add[p]  = a;
        be[p]   = b;
        wdat[p] = d;
    endtask

    // Run until every pending request is granted, bounded
    task automatic xfer();
        logic [MP-1:0] g, o;
        for (int n = 0; n < 20 && req != '0; n++) begin
            step(1'b0, g, o);
            req = req & ~g;
        end
        if (req != '0) begin
            chk("xfer_timeout", 32'(req), 32'h0);
            req = '0;
        end
    endtask

    logic [MP-1:0] g, o;
    logic [31:0]   a;

    initial begin
        rst  = 1'b1;
        req  = '0;
        wen  = '1;
        add  = '0;
        be   = '0;
        wdat = '0;
        for (int b = 0; b < NB; b++) rr[b] = 0;
        for (int p = 0; p < MP; p++) lf[p] = TCDM_LFSR_SEED ^ 16'(p);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", 32'(rv), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata0", rdat[0], 32'h0);
        chk("rst_rdata1", rdat[1], 32'h0);
        rst = 1'b0;

        set_req(0, 1'b0, BASE, 4'hF, 32'hCAFE_F00D);
        xfer();
        chk("wr_rdata", rdat[0], 32'h0);
        set_req(0, 1'b1, BASE, 4'h0, 32'h0);
        xfer();
        chk("rd_cafe", rdat[0], 32'hCAFE_F00D);

        set_req(0, 1'b0, BASE + 32'h4, 4'hF, 32'h0404_0404);
        set_req(1, 1'b0, BASE + 32'h8, 4'hF, 32'h0808_0808);
        xfer();

        set_req(0, 1'b0, BASE + 32'h20, 4'hF, 32'h1122_3344);
        xfer();
        set_req(0, 1'b0, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD);
        xfer();
        set_req(0, 1'b1, BASE + 32'h20, 4'h0, 32'h0);
        xfer();
        chk("be_merge", rdat[0], 32'h11BB_33DD);

        set_req(0, 1'b1, BASE - 32'h4, 4'h0, 32'h0);
        xfer();
        chk("oor_lo_rdata", rdat[0], 32'hDEAD_BEEF);
        chk("oor_lo_err", 32'(err[0]), 32'h1);
        step(1'b0, g, o);
        chk("oor_err_pulse", 32'(err[0]), 32'h0);
        set_req(1, 1'b0, BASE + SPAN, 4'hF, 32'h5555_5555);
        xfer();
        chk("oor_hi_err", 32'(err[1]), 32'h1);
        set_req(1, 1'b1, BASE + SPAN, 4'h0, 32'h0);
        xfer();
        chk("oor_hi_rdata", rdat[1], 32'hDEAD_BEEF);
        set_req(0, 1'b1, BASE, 4'h0, 32'h0);
        xfer();
        chk("oor_no_alias", rdat[0], 32'hCAFE_F00D);

        set_req(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
        step(1'b1, g, o);
        chk("rst_drop_rv", 32'(rv[0]), 32'h0);
        req = '0;

`ifndef SMMHA_TCDM_STALL_EN
        set_req(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
        set_req(1, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, g, o);
            chk($sformatf("alt%0d", i), 32'(o), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        req = '0;
`endif

        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < MP; p++) begin
                if (!req[p] && $urandom_range(0, 9) < 7) begin
                    a = BASE + 32'(4 * $urandom_range(0, 31));
                    if ($urandom_range(0, 15) == 0)
                        a = ($urandom_range(0, 1) == 0)
                            ? BASE - 32'(4 * $urandom_range(1, 8))
                            : BASE + SPAN + 32'(4 * $urandom_range(0, 8));
                    set_req(p, 1'($urandom_range(0, 1)), a,
                            4'($urandom_range(0, 15)), $urandom);
                end
            end
            step((c % 500) == 499, g, o);
            req = req & ~g;
        end
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

endmodule
